// File: rtl/cpu_mem_commit_if.sv
// Data-memory bus between the commit stage (master) and data memory (slave):
// request/ready handshake plus a separate rvalid return for load data.
interface cpu_mem_commit_if #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic                  dmem_byte;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [REG_WIDTH-1:0]  dmem_wdata;
  logic                  dmem_ready;
  logic                  dmem_rvalid;
  logic [REG_WIDTH-1:0]  dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_byte, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/cpu_mem_commit.sv
// Commit/memory stage: registers ALU results, runs data-memory loads/stores and stalls upstream while busy.
// Optional MEM_MISALIGN_TRAP_EN: misaligned word accesses trap instead of being aligned down.
module cpu_mem_commit #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_ADDR   = 5,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [REG_WIDTH-1:0]  in_alu_result,
  input  logic [REG_WIDTH-1:0]  in_rb_data,
  input  logic [REG_ADDR-1:0]   in_reg_dest,
  input  logic                  in_writeback,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_mem_byte,
  output logic                  stall,
  cpu_mem_commit_if.master      dmem,
  output logic                  wb_valid,
  output logic                  wb_writeback,
  output logic [REG_ADDR-1:0]   wb_reg_dest,
  output logic [REG_WIDTH-1:0]  wb_value,
  output logic [REG_WIDTH-1:0]  fw_value,
  output logic [REG_ADDR-1:0]   fw_reg_dest
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_trap
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_we;
  logic                  cap_byte;
  logic                  cap_wb;
  logic [REG_WIDTH-1:0]  cap_wdata;
  logic [REG_ADDR-1:0]   cap_dest;

  logic                  capture;
  logic                  wb_fire;
  logic                  wb_we_n;
  logic [REG_ADDR-1:0]   wb_dest_n;
  logic [REG_WIDTH-1:0]  wb_value_n;
  logic                  mem_op;
  logic [REG_WIDTH-1:0]  load_data;
  logic [REG_WIDTH-1:0]  aligned_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                  misaligned;
  logic                  trap_n;

  assign misaligned = !in_mem_byte && (in_alu_result[1:0] != 2'b00);
`endif

  assign mem_op       = in_mem_read | in_mem_write;
  assign aligned_addr = {in_alu_result[REG_WIDTH-1:2], 2'b00};
  assign load_data    = cap_byte ? {{(REG_WIDTH-8){1'b0}}, dmem.dmem_rdata[7:0]}
                                 : dmem.dmem_rdata;

  always_comb begin
    state_n    = state;
    capture    = 1'b0;
    wb_fire    = 1'b0;
    wb_we_n    = wb_writeback;
    wb_dest_n  = wb_reg_dest;
    wb_value_n = wb_value;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_n     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            wb_fire    = 1'b1;
            wb_we_n    = in_writeback;
            wb_dest_n  = in_reg_dest;
            wb_value_n = in_alu_result;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (misaligned) begin
            wb_fire   = 1'b1;
            wb_we_n   = 1'b0;
            wb_dest_n = in_reg_dest;
            trap_n    = 1'b1;
          end
`endif
          else begin
            capture = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (dmem.dmem_ready) begin
          if (cap_we) begin
            wb_fire   = 1'b1;
            wb_we_n   = 1'b0;
            wb_dest_n = cap_dest;
            state_n   = IDLE;
          end else if (dmem.dmem_rvalid) begin
            // Memory returned data in the accept cycle: skip WAIT.
            wb_fire    = 1'b1;
            wb_we_n    = cap_wb;
            wb_dest_n  = cap_dest;
            wb_value_n = load_data;
            state_n    = IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          wb_fire    = 1'b1;
          wb_we_n    = cap_wb;
          wb_dest_n  = cap_dest;
          wb_value_n = load_data;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      cap_addr     <= '0;
      cap_we       <= 1'b0;
      cap_byte     <= 1'b0;
      cap_wb       <= 1'b0;
      cap_wdata    <= '0;
      cap_dest     <= '0;
      wb_valid     <= 1'b0;
      wb_writeback <= 1'b0;
      wb_reg_dest  <= '0;
      wb_value     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      wb_valid     <= wb_fire;
      wb_writeback <= wb_we_n;
      wb_reg_dest  <= wb_dest_n;
      wb_value     <= wb_value_n;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_trap <= trap_n;
`endif
      if (capture) begin
        // Load wins when read and write are both set; word addresses are forced aligned.
        cap_addr  <= in_mem_byte ? ADDR_WIDTH'(in_alu_result) : ADDR_WIDTH'(aligned_addr);
        cap_we    <= in_mem_write & ~in_mem_read;
        cap_byte  <= in_mem_byte;
        cap_wb    <= in_writeback;
        cap_wdata <= in_mem_byte ? {{(REG_WIDTH-8){1'b0}}, in_rb_data[7:0]} : in_rb_data;
        cap_dest  <= in_reg_dest;
      end
    end
  end

  assign stall           = (state != IDLE);
  assign dmem.dmem_req   = (state == REQ);
  assign dmem.dmem_we    = cap_we;
  assign dmem.dmem_byte  = cap_byte;
  assign dmem.dmem_addr  = cap_addr;
  assign dmem.dmem_wdata = cap_wdata;

  assign fw_value    = wb_value;
  assign fw_reg_dest = (wb_valid && wb_writeback) ? wb_reg_dest : '0;

endmodule

// File: tb/tb_cpu_mem_commit.sv
// Self-checking bench for cpu_mem_commit: directed cases followed by randomized transactions
// against a transaction-level reference model.
module tb_cpu_mem_commit;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_rb_data;
  logic [4:0]  in_reg_dest;
  logic        in_writeback, in_mem_read, in_mem_write, in_mem_byte;
  logic        stall;
  logic        wb_valid, wb_writeback;
  logic [4:0]  wb_reg_dest, fw_reg_dest;
  logic [31:0] wb_value, fw_value;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] model_value;

  cpu_mem_commit_if #(.REG_WIDTH(32), .ADDR_WIDTH(32)) dmem_if ();

  cpu_mem_commit #(.REG_WIDTH(32), .REG_ADDR(5), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_rb_data(in_rb_data), .in_reg_dest(in_reg_dest), .in_writeback(in_writeback),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_byte(in_mem_byte),
    .stall(stall), .dmem(dmem_if.master), .wb_valid(wb_valid), .wb_writeback(wb_writeback),
    .wb_reg_dest(wb_reg_dest), .wb_value(wb_value), .fw_value(fw_value), .fw_reg_dest(fw_reg_dest)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_alu_result = '0; in_rb_data = '0; in_reg_dest = '0;
    in_writeback = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_mem_byte = 1'b0;
  endtask

  // Random upstream activity; must have no effect while the stage is stalled.
  task automatic drive_noise();
    in_valid = 1'($urandom_range(0, 1)); in_alu_result = $urandom; in_rb_data = $urandom;
    in_reg_dest = 5'($urandom); in_writeback = 1'($urandom); in_mem_read = 1'($urandom);
    in_mem_write = 1'($urandom); in_mem_byte = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clock); @(negedge clock);
  endtask

  task automatic txn(input logic [31:0] alu, input logic [31:0] rb, input logic [4:0] dest,
                     input logic wbe, input logic rd, input logic wr, input logic bt,
                     input int unsigned rdy_lat, input int unsigned rv_lat,
                     input logic same, input logic [31:0] rdata);
    logic mem, load, trap;
    logic [31:0] eaddr, ewdata;
    mem  = rd | wr;
    load = rd;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mem && !bt && (alu % 4 != 0);
`endif
    eaddr  = bt ? alu : alu - (alu % 4);
    ewdata = bt ? rb % 256 : rb;

    in_valid = 1'b1; in_alu_result = alu; in_rb_data = rb; in_reg_dest = dest;
    in_writeback = wbe; in_mem_read = rd; in_mem_write = wr; in_mem_byte = bt;
    tick();

    if (!mem || trap) begin
      clear_in();
      if (!trap) model_value = alu;
      check("alu_wb_valid", wb_valid, 1);
      check("alu_stall", stall, 0);
      check("alu_dmem_req", dmem_if.dmem_req, 0);
      check("alu_wb_writeback", wb_writeback, trap ? 0 : wbe);
      check("alu_wb_value", wb_value, model_value);
      check("alu_fw_value", fw_value, model_value);
      check("alu_fw_reg_dest", fw_reg_dest, (!trap && wbe) ? dest : 0);
      if (!trap) check("alu_wb_reg_dest", wb_reg_dest, dest);
`ifdef MEM_MISALIGN_TRAP_EN
      check("trap_pulse", misalign_trap, trap);
`endif
    end else begin
      for (int unsigned i = 0; i <= rdy_lat; i++) begin
        check("req_stall", stall, 1);
        check("req_dmem_req", dmem_if.dmem_req, 1);
        check("req_addr", dmem_if.dmem_addr, eaddr);
        check("req_we", dmem_if.dmem_we, wr && !rd);
        check("req_byte", dmem_if.dmem_byte, bt);
        check("req_wdata", dmem_if.dmem_wdata, ewdata);
        check("req_wb_valid", wb_valid, 0);
        drive_noise();
        dmem_if.dmem_ready  = (i == rdy_lat);
        dmem_if.dmem_rvalid = load ? ((i == rdy_lat) && same) : 1'($urandom);
        dmem_if.dmem_rdata  = (i == rdy_lat) ? rdata : $urandom;
        tick();
      end
      dmem_if.dmem_ready = 1'b0; dmem_if.dmem_rvalid = 1'b0;
      if (load && !same) begin
        for (int unsigned j = 0; j <= rv_lat; j++) begin
          check("wait_stall", stall, 1);
          check("wait_dmem_req", dmem_if.dmem_req, 0);
          check("wait_wb_valid", wb_valid, 0);
          drive_noise();
          dmem_if.dmem_rvalid = (j == rv_lat);
          dmem_if.dmem_rdata  = (j == rv_lat) ? rdata : $urandom;
          tick();
        end
        dmem_if.dmem_rvalid = 1'b0;
      end
      clear_in();
      if (load) model_value = bt ? rdata % 256 : rdata;
      check("mem_wb_valid", wb_valid, 1);
      check("mem_stall", stall, 0);
      check("mem_dmem_req", dmem_if.dmem_req, 0);
      check("mem_wb_writeback", wb_writeback, load ? wbe : 0);
      check("mem_wb_value", wb_value, model_value);
      check("mem_fw_value", fw_value, model_value);
      check("mem_fw_reg_dest", fw_reg_dest, (load && wbe) ? dest : 0);
      if (load) check("mem_wb_reg_dest", wb_reg_dest, dest);
    end
    tick();
    check("pulse_end_wb_valid", wb_valid, 0);
    check("pulse_end_fw_reg_dest", fw_reg_dest, 0);
    check("pulse_end_stall", stall, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("trap_end", misalign_trap, 0);
`endif
  endtask

  initial begin
    clear_in();
    dmem_if.dmem_ready = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = '0;
    reset = 1'b0;
    model_value = '0;
    @(negedge clock); tick();
    check("rst_stall", stall, 0);
    check("rst_dmem_req", dmem_if.dmem_req, 0);
    check("rst_dmem_we", dmem_if.dmem_we, 0);
    check("rst_dmem_byte", dmem_if.dmem_byte, 0);
    check("rst_dmem_addr", dmem_if.dmem_addr, 0);
    check("rst_dmem_wdata", dmem_if.dmem_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_writeback", wb_writeback, 0);
    check("rst_wb_reg_dest", wb_reg_dest, 0);
    check("rst_wb_value", wb_value, 0);
    check("rst_fw_value", fw_value, 0);
    check("rst_fw_reg_dest", fw_reg_dest, 0);
    reset = 1'b1;
    tick();

    // Directed cases.
    txn(32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    txn(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 32'hDEAD_BEEF);
    txn(32'h0000_0103, 32'h1234_56AB, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 32'h0);
    txn(32'h0000_0041, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 32'hFFFF_FF80);
    txn(32'h0000_0102, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 32'h0BAD_F00D);
    txn(32'h0000_0200, 32'h5555_AAAA, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2, 1'b0, 32'h1357_9BDF);

    // Stray rvalid while idle must not produce a writeback.
    dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'hCAFE_0001;
    tick();
    dmem_if.dmem_rvalid = 1'b0;
    check("idle_rvalid_wb_valid", wb_valid, 0);
    check("idle_rvalid_value", wb_value, model_value);

    // Reset while waiting for load data abandons the load.
    in_valid = 1'b1; in_alu_result = 32'h0000_0300; in_reg_dest = 5'd4;
    in_writeback = 1'b1; in_mem_read = 1'b1;
    tick();
    clear_in();
    dmem_if.dmem_ready = 1'b1;
    tick();
    dmem_if.dmem_ready = 1'b0;
    check("pre_rst_wait_stall", stall, 1);
    reset = 1'b0;
    tick();
    check("rst_wait_stall", stall, 0);
    check("rst_wait_dmem_req", dmem_if.dmem_req, 0);
    reset = 1'b1;
    model_value = '0;
    dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'h7777_7777;
    tick();
    dmem_if.dmem_rvalid = 1'b0;
    check("post_rst_wb_valid", wb_valid, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_dmem_req", dmem_if.dmem_req, 0);
    check("post_rst_wb_value", wb_value, 0);

    // Randomized transactions.
    for (int k = 0; k < 60; k++) begin
      logic rd, wr;
      rd = 1'($urandom); wr = 1'($urandom);
      txn($urandom, $urandom, 5'($urandom), 1'($urandom), rd, wr, 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
